// File: rtl/pong_video_timing.sv
// -----------------------------------------------------------------------------
// pong_video_timing
//
// Free-running raster timing generator for the pong video path.
//   * Produces the H_CNT/V_CNT pixel pointers used by the drawer, and a
//     FRAME_TICK pulse while the pointers sit at (0,0) so game logic can step
//     once per frame.
//   * Decodes DE/HSYNC/VSYNC from the pointers and delays them so that they
//     line up with the drawer's colour, which returns PIPE_DLY cycles after
//     its pointer.
//   * Registers the returned colour, forcing black outside the active area.
//     The colour register and the last sync/DE stage share one clock edge.
//
// Ports
//   CLK                        pixel clock
//   RST                        synchronous reset, active high
//   H_CNT[10:0], V_CNT[10:0]   current pixel pointer
//   FRAME_TICK                 1 while pointer == (0,0), but not the first
//                              cycle after reset release
//   RED_IN/GREEN_IN/BLUE_IN    colour of the pixel pointed at PIPE_DLY
//                              cycles earlier
//   VGA_RED/GREEN/BLUE         registered colour to the PHY
//   HSYNC, VSYNC, DE           sync/data enable, aligned with VGA_*
//
// Total latency from pointer (h,v) to its VGA_*/HSYNC/VSYNC/DE is PIPE_DLY+1.
// H_TOTAL and V_TOTAL must not exceed 2048; PIPE_DLY must lie in 0..7.
// -----------------------------------------------------------------------------
module pong_video_timing #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   PIPE_DLY = 1
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [10:0] H_CNT,
  output logic [10:0] V_CNT,
  output logic        FRAME_TICK,
  input  logic [7:0]  RED_IN,
  input  logic [7:0]  GREEN_IN,
  input  logic [7:0]  BLUE_IN,
  output logic [7:0]  VGA_RED,
  output logic [7:0]  VGA_GREEN,
  output logic [7:0]  VGA_BLUE,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        DE
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

  // Decode bounds are 12 bits wide so a sync pulse ending exactly at 2048
  // still compares correctly against the zero-extended counters.
  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYN_BEG  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYN_END  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYN_BEG  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYN_END  = 12'(V_ACTIVE + V_FP + V_SYNC);

  // ---------------------------------------------------------------------------
  // Pixel pointers and frame tick
  // ---------------------------------------------------------------------------
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        frame_tick_q, frame_tick_d;

  always_comb begin
    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + 11'd1;
      end
    end
    // The tick is registered alongside the counters so it is high exactly
    // while they read (0,0); the reset branch keeps it low on the (0,0)
    // that directly follows release.
    frame_tick_d = (h_cnt_d == '0) && (v_cnt_d == '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign H_CNT      = h_cnt_q;
  assign V_CNT      = v_cnt_q;
  assign FRAME_TICK = frame_tick_q;

  // ---------------------------------------------------------------------------
  // Raw timing decode from the current pointer
  // ---------------------------------------------------------------------------
  logic de_raw, hs_raw, vs_raw;

  assign de_raw = ({1'b0, h_cnt_q} < H_ACT_END) && ({1'b0, v_cnt_q} < V_ACT_END);
  assign hs_raw = ({1'b0, h_cnt_q} >= H_SYN_BEG) && ({1'b0, h_cnt_q} < H_SYN_END);
  assign vs_raw = ({1'b0, v_cnt_q} >= V_SYN_BEG) && ({1'b0, v_cnt_q} < V_SYN_END);

  // ---------------------------------------------------------------------------
  // Alignment shift register, depth PIPE_DLY+1.
  // The tap vectors put the raw decode at index 0 and stage k at index k+1,
  // so tap[PIPE_DLY] is "delayed by PIPE_DLY" (the raw value when PIPE_DLY=0)
  // and tap[PIPE_DLY+1] is the final stage driving the outputs. Sync flags are
  // held as "active" bits; polarity is applied only at the output, so clearing
  // the stages gives inactive sync levels.
  // ---------------------------------------------------------------------------
  logic [PIPE_DLY:0]   de_pipe_q, hs_pipe_q, vs_pipe_q;
  logic [PIPE_DLY:0]   de_pipe_d, hs_pipe_d, vs_pipe_d;
  logic [PIPE_DLY+1:0] de_tap, hs_tap, vs_tap;

  assign de_tap = {de_pipe_q, de_raw};
  assign hs_tap = {hs_pipe_q, hs_raw};
  assign vs_tap = {vs_pipe_q, vs_raw};

  assign de_pipe_d = de_tap[PIPE_DLY:0];
  assign hs_pipe_d = hs_tap[PIPE_DLY:0];
  assign vs_pipe_d = vs_tap[PIPE_DLY:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      de_pipe_q <= '0;
      hs_pipe_q <= '0;
      vs_pipe_q <= '0;
    end else begin
      de_pipe_q <= de_pipe_d;
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Colour register: the incoming colour belongs to the pixel whose DE is at
  // tap[PIPE_DLY]; registering it lands it next to tap[PIPE_DLY+1].
  // ---------------------------------------------------------------------------
  logic [7:0] vga_red_q, vga_green_q, vga_blue_q;
  logic       colour_en;

  assign colour_en = de_tap[PIPE_DLY];

  always_ff @(posedge CLK) begin
    if (RST) begin
      vga_red_q   <= 8'h00;
      vga_green_q <= 8'h00;
      vga_blue_q  <= 8'h00;
    end else begin
      vga_red_q   <= colour_en ? RED_IN   : 8'h00;
      vga_green_q <= colour_en ? GREEN_IN : 8'h00;
      vga_blue_q  <= colour_en ? BLUE_IN  : 8'h00;
    end
  end

  assign VGA_RED   = vga_red_q;
  assign VGA_GREEN = vga_green_q;
  assign VGA_BLUE  = vga_blue_q;

  assign DE    = de_tap[PIPE_DLY+1];
  assign HSYNC = hs_tap[PIPE_DLY+1] ? HS_POL : ~HS_POL;
  assign VSYNC = vs_tap[PIPE_DLY+1] ? VS_POL : ~VS_POL;

endmodule

// File: tb/tb_pong_video_timing.sv
// -----------------------------------------------------------------------------
// Bench for pong_video_timing.
// One full-size instance (default 1650x750 timing, PIPE_DLY=1) for counter,
// line-wrap and HSYNC checks, plus four scaled-down instances (28x13 raster)
// so whole frames fit in a short run:
//   inst0 PIPE_DLY=0, inst1 PIPE_DLY=1, inst2 PIPE_DLY=3,
//   inst3 PIPE_DLY=1 with HS_POL=VS_POL=0.
// The small instances are compared cycle by cycle against an arithmetic
// raster model derived from the cycle count since reset release.
// -----------------------------------------------------------------------------
module tb_pong_video_timing;

  localparam int HA  = 16;
  localparam int HF  = 3;
  localparam int HSW = 4;
  localparam int HB  = 5;
  localparam int VA  = 6;
  localparam int VF  = 2;
  localparam int VSW = 2;
  localparam int VB  = 3;
  localparam int HT  = HA + HF + HSW + HB;
  localparam int VT  = VA + VF + VSW + VB;
  localparam int FT  = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // full-size instance
  logic [10:0] dh, dv;
  logic        dtick, dhs, dvs, dde;
  logic [7:0]  dr, dg, db;
  logic [7:0]  drin = 8'h00, dgin = 8'h00, dbin = 8'h00;

  pong_video_timing u_full (
    .CLK(clk), .RST(rst),
    .H_CNT(dh), .V_CNT(dv), .FRAME_TICK(dtick),
    .RED_IN(drin), .GREEN_IN(dgin), .BLUE_IN(dbin),
    .VGA_RED(dr), .VGA_GREEN(dg), .VGA_BLUE(db),
    .HSYNC(dhs), .VSYNC(dvs), .DE(dde)
  );

  // scaled-down instances
  logic [10:0] s_h [4];
  logic [10:0] s_v [4];
  logic        s_tick [4];
  logic        s_hs [4];
  logic        s_vs [4];
  logic        s_de [4];
  logic [7:0]  s_r [4];
  logic [7:0]  s_g [4];
  logic [7:0]  s_b [4];
  logic [7:0]  s_rin [4];
  logic [7:0]  s_gin [4];
  logic [7:0]  s_bin [4];
  logic [7:0]  g_prev [4];
  logic [7:0]  b_prev [4];

  function automatic int dly_of(input int i);
    return (i == 0) ? 0 : ((i == 2) ? 3 : 1);
  endfunction

  function automatic logic pol_of(input int i);
    return (i == 3) ? 1'b0 : 1'b1;
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    pong_video_timing #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
      .HS_POL((gi == 3) ? 1'b0 : 1'b1),
      .VS_POL((gi == 3) ? 1'b0 : 1'b1),
      .PIPE_DLY((gi == 0) ? 0 : ((gi == 2) ? 3 : 1))
    ) u_dut (
      .CLK(clk), .RST(rst),
      .H_CNT(s_h[gi]), .V_CNT(s_v[gi]), .FRAME_TICK(s_tick[gi]),
      .RED_IN(s_rin[gi]), .GREEN_IN(s_gin[gi]), .BLUE_IN(s_bin[gi]),
      .VGA_RED(s_r[gi]), .VGA_GREEN(s_g[gi]), .VGA_BLUE(s_b[gi]),
      .HSYNC(s_hs[gi]), .VSYNC(s_vs[gi]), .DE(s_de[gi])
    );
  end

  // One clock: track cycles since release, drive the drawer's colour for
  // this cycle (red = pixel index of the pixel PIPE_DLY back, 8'hFF while
  // that pixel is blank), then return at the falling edge for sampling.
  task automatic tick();
    @(posedge clk);
    if (rst) cyc = 0;
    else     cyc = cyc + 1;
    #1;
    drin = 8'($urandom);
    dgin = 8'($urandom);
    dbin = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      int q;
      q = cyc - dly_of(i);
      g_prev[i] = s_gin[i];
      b_prev[i] = s_bin[i];
      if (q >= 0 && (q % HT) < HA && ((q / HT) % VT) < VA)
        s_rin[i] = 8'(q % HT);
      else
        s_rin[i] = 8'hFF;
      s_gin[i] = 8'($urandom);
      s_bin[i] = 8'($urandom);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({dh, dv, dtick, dde, dhs, dvs} !== 26'd0) begin
      n_bad++;
      $display("FAIL reset_full_ctrl got h=%0d v=%0d tick=%b de=%b hs=%b vs=%b expected all 0",
               dh, dv, dtick, dde, dhs, dvs);
    end
    n_cmp++;
    if ({dr, dg, db} !== 24'd0) begin
      n_bad++;
      $display("FAIL reset_full_rgb got %h expected 000000", {dr, dg, db});
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({s_h[i], s_v[i], s_tick[i], s_de[i], s_hs[i], s_vs[i], s_r[i], s_g[i], s_b[i]} !==
          {22'd0, 1'b0, 1'b0, ~pol_of(i), ~pol_of(i), 24'd0}) begin
        n_bad++;
        $display("FAIL reset_small inst%0d got h=%0d v=%0d tick=%b de=%b hs=%b vs=%b rgb=%h expected zeros, syncs=%b",
                 i, s_h[i], s_v[i], s_tick[i], s_de[i], s_hs[i], s_vs[i],
                 {s_r[i], s_g[i], s_b[i]}, ~pol_of(i));
      end
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({dh, dv, dtick} !== {11'd1, 11'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL first_count got h=%0d v=%0d tick=%b expected h=1 v=0 tick=0", dh, dv, dtick);
    end
    $display("test_reset done at cycle %0d", cyc);
  endtask

  task automatic test_line_wrap();
    int guard;
    int cnt;
    logic [10:0] v0;
    guard = 0;
    while (dh !== 11'd1649 && guard < 2000) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (dh !== 11'd1649) begin
      n_bad++;
      $display("FAIL reach_1649 got h=%0d expected 1649 within 2000 cycles", dh);
    end
    v0 = dv;
    tick();
    n_cmp++;
    if ({dh, dv} !== {11'd0, 11'(v0 + 11'd1)}) begin
      n_bad++;
      $display("FAIL line_wrap got h=%0d v=%0d expected h=0 v=%0d", dh, dv, v0 + 11'd1);
    end
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (dh !== 11'd0 && cnt < 2000);
    n_cmp++;
    if (cnt != 1650) begin
      n_bad++;
      $display("FAIL line_length got %0d cycles expected 1650", cnt);
    end
    $display("test_line_wrap done at cycle %0d", cyc);
  endtask

  // Starts at H_CNT=0 of a line; watches one whole line.
  task automatic test_hsync();
    int c1390;
    int rise;
    int rises;
    int width;
    logic prev;
    c1390 = -100;
    rise  = -1;
    rises = 0;
    width = 0;
    prev  = dhs;
    for (int k = 0; k < 1650; k++) begin
      if (dh == 11'd1390) c1390 = cyc;
      if (dhs && !prev) begin
        rise = cyc;
        rises++;
      end
      if (dhs) width++;
      prev = dhs;
      tick();
    end
    n_cmp++;
    if (rise - c1390 != 2) begin
      n_bad++;
      $display("FAIL hsync_delay got %0d cycles after h=1390 expected 2", rise - c1390);
    end
    n_cmp++;
    if (width != 40) begin
      n_bad++;
      $display("FAIL hsync_width got %0d expected 40", width);
    end
    n_cmp++;
    if (rises != 1) begin
      n_bad++;
      $display("FAIL hsync_count got %0d pulses expected 1", rises);
    end
    $display("test_hsync done at cycle %0d", cyc);
  endtask

  // Two-plus frames on every scaled instance, all outputs against the model.
  task automatic test_alignment();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2 * FT + 8; k++) begin
      for (int i = 0; i < 4; i++) begin
        int n, d, p, ph, pv, eh, ev;
        logic etick, ede, ehs, evs;
        logic [23:0] ergb;
        n  = cyc;
        d  = dly_of(i);
        eh = n % HT;
        ev = (n / HT) % VT;
        etick = (n > 0) && (n % FT == 0);
        ede = 1'b0; ehs = 1'b0; evs = 1'b0; ph = 0;
        if (n >= d + 1) begin
          p   = n - d - 1;
          ph  = p % HT;
          pv  = (p / HT) % VT;
          ede = (ph < HA) && (pv < VA);
          ehs = (ph >= HA + HF) && (ph < HA + HF + HSW);
          evs = (pv >= VA + VF) && (pv < VA + VF + VSW);
        end
        ergb = ede ? {8'(ph), g_prev[i], b_prev[i]} : 24'd0;
        n_cmp++;
        if ({s_h[i], s_v[i], s_tick[i]} !== {11'(eh), 11'(ev), etick}) begin
          n_bad++;
          $display("FAIL counters inst%0d cyc%0d got h=%0d v=%0d tick=%b expected h=%0d v=%0d tick=%b",
                   i, n, s_h[i], s_v[i], s_tick[i], eh, ev, etick);
        end
        n_cmp++;
        if ({s_de[i], s_hs[i], s_vs[i]} !==
            {ede, ehs ? pol_of(i) : ~pol_of(i), evs ? pol_of(i) : ~pol_of(i)}) begin
          n_bad++;
          $display("FAIL sync inst%0d cyc%0d got de/hs/vs=%b%b%b expected %b%b%b",
                   i, n, s_de[i], s_hs[i], s_vs[i], ede,
                   ehs ? pol_of(i) : ~pol_of(i), evs ? pol_of(i) : ~pol_of(i));
        end
        n_cmp++;
        if ({s_r[i], s_g[i], s_b[i]} !== ergb) begin
          n_bad++;
          $display("FAIL colour inst%0d cyc%0d got %h expected %h", i, n,
                   {s_r[i], s_g[i], s_b[i]}, ergb);
        end
      end
      tick();
    end
    $display("test_alignment done at cycle %0d", cyc);
  endtask

  task automatic test_midframe_reset();
    int first_de;
    int guard;
    repeat ($urandom_range(40, FT - 40)) tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({s_h[i], s_v[i], s_de[i], s_hs[i], s_vs[i]} !==
          {22'd0, 1'b0, ~pol_of(i), ~pol_of(i)}) begin
        n_bad++;
        $display("FAIL mid_reset inst%0d got h=%0d v=%0d de=%b hs=%b vs=%b expected 0 0 0 %b %b",
                 i, s_h[i], s_v[i], s_de[i], s_hs[i], s_vs[i], ~pol_of(i), ~pol_of(i));
      end
    end
    n_cmp++;
    if ({dh, dv, dde, dhs, dvs} !== 25'd0) begin
      n_bad++;
      $display("FAIL mid_reset_full got h=%0d v=%0d de=%b hs=%b vs=%b expected all 0",
               dh, dv, dde, dhs, dvs);
    end
    rst = 1'b0;
    first_de = -1;
    guard = 0;
    do begin
      tick();
      guard++;
      if (s_de[1] && first_de < 0) first_de = cyc;
    end while (!s_tick[1] && guard < 2 * FT);
    n_cmp++;
    if (first_de != dly_of(1) + 1) begin
      n_bad++;
      $display("FAIL first_de got cycle %0d expected %0d", first_de, dly_of(1) + 1);
    end
    n_cmp++;
    if (cyc != FT || {s_h[1], s_v[1]} !== 22'd0) begin
      n_bad++;
      $display("FAIL frame_after_reset got tick at cycle %0d h=%0d v=%0d expected cycle %0d at 0,0",
               cyc, s_h[1], s_v[1], FT);
    end
    $display("test_midframe_reset done at cycle %0d", cyc);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      s_rin[i]  = 8'hFF;
      s_gin[i]  = 8'h00;
      s_bin[i]  = 8'h00;
      g_prev[i] = 8'h00;
      b_prev[i] = 8'h00;
    end
    test_reset();
    test_line_wrap();
    test_hsync();
    test_alignment();
    test_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
